// File: rtl/decode_pkg.sv
// Shared decode constants: instruction classes, function codes, ALU selects
// and the load-use stall FSM state type.
package decode_pkg;

  // Instruction class, in_insn[15:14]
  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  // ALU-class function codes that do not map straight onto an ALU select
  localparam logic [3:0] FN_CMP = 4'b0101;
  localparam logic [3:0] FN_MOV = 4'b0110;
  localparam logic [3:0] FN_IDT = 4'b1100;

  // Immediate-class sub-opcodes, in_insn[13:11]
  localparam logic [2:0] IMM_LI   = 3'b000;
  localparam logic [2:0] IMM_ADDI = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b100;
  localparam logic [2:0] IMM_BCC  = 3'b111;

  // Control bundle field widths
  localparam int ALU_OP_W = 4;
  localparam int COND_W   = 3;

  // ALU selects used by non-ALU classes and remapped functions
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_IDT = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_NON = 4'b1111;

  // RUN: normal issue; BUBBLE: output register holds a load-use bubble
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stall_state_t;

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational instruction -> control bundle decoder, including
// which source operands the instruction actually reads.
module decode_comb
  import decode_pkg::*;
#(
  parameter int INSN_W = 16,
  parameter int REG_AW = 3
) (
  input  logic [INSN_W-1:0]   i_insn,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [REG_AW-1:0]   o_rd,
  output logic                o_rf_we,
  output logic                o_mem_we,
  output logic                o_is_load,
  output logic                o_flag_we,
  output logic                o_pc_load,
  output logic [COND_W-1:0]   o_cond,
  output logic                o_sign_ex,
  output logic [REG_AW-1:0]   o_rs_a,
  output logic [REG_AW-1:0]   o_rs_b,
  output logic                o_read_a,
  output logic                o_read_b
);

  logic [1:0] w_cls;
  logic [3:0] w_func;
  logic [2:0] w_sub;
  logic       w_unused_imm;

  assign w_cls        = i_insn[15:14];
  assign w_func       = i_insn[7:4];
  assign w_sub        = i_insn[13:11];
  // Low immediate bits travel to execute on a separate path
  assign w_unused_imm = ^i_insn[3:0];

  // Decode one instruction; defaults describe a side-effect-free NON
  always_comb begin
    o_alu_op  = ALU_NON;
    o_rd      = REG_AW'(i_insn[10:8]);
    o_rf_we   = 1'b0;
    o_mem_we  = 1'b0;
    o_is_load = 1'b0;
    o_flag_we = 1'b0;
    o_pc_load = 1'b0;
    o_cond    = i_insn[10:8];
    o_sign_ex = 1'b1;
    o_rs_a    = REG_AW'(i_insn[10:8]);
    o_rs_b    = REG_AW'(i_insn[13:11]);
    o_read_a  = 1'b0;
    o_read_b  = 1'b0;
    case (w_cls)
      CLS_ALU: begin
        o_sign_ex = 1'b0;
        o_read_a  = 1'b1;
        case (w_func)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
          4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
            o_alu_op  = w_func;
            o_rf_we   = 1'b1;
            o_flag_we = 1'b1;
            o_read_b  = 1'b1;
          end
          FN_CMP: begin
            o_alu_op  = ALU_SUB;
            o_flag_we = 1'b1;
            o_read_b  = 1'b1;
          end
          FN_MOV: begin
            o_alu_op  = ALU_IDT;
            o_rf_we   = 1'b1;
            o_flag_we = 1'b1;
          end
          FN_IDT: begin
            o_alu_op  = ALU_IDT;
            o_rf_we   = 1'b1;
          end
          default: ;
        endcase
      end
      CLS_LD: begin
        o_rd      = REG_AW'(i_insn[13:11]);
        o_alu_op  = ALU_ADD;
        o_rf_we   = 1'b1;
        o_is_load = 1'b1;
        o_read_a  = 1'b1;
      end
      CLS_ST: begin
        o_alu_op  = ALU_ADD;
        o_mem_we  = 1'b1;
        o_read_a  = 1'b1;
        o_read_b  = 1'b1;
      end
      default: begin // CLS_IMM
        case (w_sub)
          IMM_LI: begin
            o_alu_op = ALU_IDT;
            o_rf_we  = 1'b1;
          end
          IMM_ADDI: begin
            o_alu_op  = ALU_ADD;
            o_rf_we   = 1'b1;
            o_flag_we = 1'b1;
            o_read_a  = 1'b1;
          end
          IMM_B, IMM_BCC: begin
            o_alu_op  = ALU_ADD;
            o_pc_load = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input and output, writer history for
// forwarding selects, and a RUN/BUBBLE FSM that inserts load-use bubbles.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the sender holds its payload stable while valid & !ready, and valid
// never depends combinationally on ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSN_W     = 16,
  parameter int REG_AW     = 3,
  parameter int HIST_DEPTH = 2,
  localparam int FWD_W     = $clog2(HIST_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSN_W-1:0]   in_insn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [REG_AW-1:0]   out_rd,
  output logic                out_rf_we,
  output logic                out_mem_we,
  output logic                out_is_load,
  output logic                out_flag_we,
  output logic                out_pc_load,
  output logic [COND_W-1:0]   out_cond,
  output logic                out_sign_ex,
  output logic [REG_AW-1:0]   out_rs_a,
  output logic [REG_AW-1:0]   out_rs_b,
  output logic [FWD_W-1:0]    out_fwd_a,
  output logic [FWD_W-1:0]    out_fwd_b,
  output logic                out_stall
);

  logic [ALU_OP_W-1:0] w_alu_op;
  logic [REG_AW-1:0]   w_rd, w_rs_a, w_rs_b;
  logic                w_rf_we, w_mem_we, w_is_load, w_flag_we, w_pc_load;
  logic                w_sign_ex, w_read_a, w_read_b;
  logic [COND_W-1:0]   w_cond;

  decode_comb #(.INSN_W(INSN_W), .REG_AW(REG_AW)) u_decode_comb (
    .i_insn    (in_insn),
    .o_alu_op  (w_alu_op),
    .o_rd      (w_rd),
    .o_rf_we   (w_rf_we),
    .o_mem_we  (w_mem_we),
    .o_is_load (w_is_load),
    .o_flag_we (w_flag_we),
    .o_pc_load (w_pc_load),
    .o_cond    (w_cond),
    .o_sign_ex (w_sign_ex),
    .o_rs_a    (w_rs_a),
    .o_rs_b    (w_rs_b),
    .o_read_a  (w_read_a),
    .o_read_b  (w_read_b)
  );

  // Output bundle registers
  logic                r_out_valid;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [REG_AW-1:0]   r_rd, r_rs_a, r_rs_b;
  logic                r_rf_we, r_mem_we, r_is_load, r_flag_we, r_pc_load, r_sign_ex;
  logic [COND_W-1:0]   r_cond;
  logic [FWD_W-1:0]    r_fwd_a, r_fwd_b;

  // Writer history; entry 1 is the youngest bundle that left the stage
  logic [HIST_DEPTH:1]             r_hist_v, r_hist_we, w_hist_v, w_hist_we;
  logic [HIST_DEPTH:1][REG_AW-1:0] r_hist_rd, w_hist_rd;

  stall_state_t r_state, w_state_nxt;

  logic             w_load_use, w_accept, w_shift;
  logic [FWD_W-1:0] w_fwd_a, w_fwd_b;

  // The load sitting in the output register cannot forward to its consumer
  assign w_load_use = r_out_valid & r_is_load &
                      ((w_read_a & (w_rs_a == r_rd)) | (w_read_b & (w_rs_b == r_rd)));
  assign in_ready   = (~r_out_valid | out_ready) & ~w_load_use;
  assign w_accept   = in_valid & in_ready & ~flush;
  // History advances when a real bundle drains or a bubble is replaced
  assign w_shift    = (r_out_valid & out_ready) | (r_state == ST_BUBBLE);

  // Next history view; forwarding is resolved against it so the bundle just
  // leaving the stage is already entry 1 for the instruction being accepted
  always_comb begin
    w_hist_v  = r_hist_v;
    w_hist_we = r_hist_we;
    w_hist_rd = r_hist_rd;
    if (w_shift) begin
      for (int k = HIST_DEPTH; k >= 2; k--) begin
        w_hist_v[k]  = r_hist_v[k-1];
        w_hist_we[k] = r_hist_we[k-1];
        w_hist_rd[k] = r_hist_rd[k-1];
      end
      w_hist_v[1]  = r_out_valid;
      w_hist_we[1] = r_out_valid & r_rf_we;
      w_hist_rd[1] = r_rd;
    end
  end

  // Forwarding selects: scan oldest to youngest so the youngest writer wins
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = HIST_DEPTH; k >= 1; k--) begin
      if (w_read_a && w_hist_v[k] && w_hist_we[k] && (w_hist_rd[k] == w_rs_a))
        w_fwd_a = FWD_W'(k);
      if (w_read_b && w_hist_v[k] && w_hist_we[k] && (w_hist_rd[k] == w_rs_b))
        w_fwd_b = FWD_W'(k);
    end
  end

  // Stall FSM next state: a bubble follows a draining load with a waiting consumer
  always_comb begin
    w_state_nxt = ST_RUN;
    if (!flush && (r_state == ST_RUN) && in_valid && out_ready && w_load_use)
      w_state_nxt = ST_BUBBLE;
  end

  // Stall FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // History shift register; flush empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_v  <= '0;
      r_hist_we <= '0;
      r_hist_rd <= '0;
    end else if (flush) begin
      r_hist_v  <= '0;
      r_hist_we <= '0;
      r_hist_rd <= '0;
    end else begin
      r_hist_v  <= w_hist_v;
      r_hist_we <= w_hist_we;
      r_hist_rd <= w_hist_rd;
    end
  end

  // Output bundle: load on accept, drop valid on drain, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_rf_we     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_is_load   <= 1'b0;
      r_flag_we   <= 1'b0;
      r_pc_load   <= 1'b0;
      r_cond      <= '0;
      r_sign_ex   <= 1'b0;
      r_rs_a      <= '0;
      r_rs_b      <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_op    <= w_alu_op;
      r_rd        <= w_rd;
      r_rf_we     <= w_rf_we;
      r_mem_we    <= w_mem_we;
      r_is_load   <= w_is_load;
      r_flag_we   <= w_flag_we;
      r_pc_load   <= w_pc_load;
      r_cond      <= w_cond;
      r_sign_ex   <= w_sign_ex;
      r_rs_a      <= w_rs_a;
      r_rs_b      <= w_rs_b;
      r_fwd_a     <= w_fwd_a;
      r_fwd_b     <= w_fwd_b;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_alu_op  = r_alu_op;
  assign out_rd      = r_rd;
  assign out_rf_we   = r_rf_we;
  assign out_mem_we  = r_mem_we;
  assign out_is_load = r_is_load;
  assign out_flag_we = r_flag_we;
  assign out_pc_load = r_pc_load;
  assign out_cond    = r_cond;
  assign out_sign_ex = r_sign_ex;
  assign out_rs_a    = r_rs_a;
  assign out_rs_b    = r_rs_b;
  assign out_fwd_a   = r_fwd_a;
  assign out_fwd_b   = r_fwd_b;
  assign out_stall   = (r_state == ST_BUBBLE);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode classes, forwarding, load-use
// bubble, backpressure, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_insn;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_rd, out_cond, out_rs_a, out_rs_b;
  logic        out_rf_we, out_mem_we, out_is_load, out_flag_we, out_pc_load, out_sign_ex, out_stall;
  logic [1:0]  out_fwd_a, out_fwd_b;

  int checks   = 0;
  int failures = 0;

  // Clock: 10 time-unit period
  always #5 clk = ~clk;

  decode_stage #(.INSN_W(16), .REG_AW(3), .HIST_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rf_we(out_rf_we),
    .out_mem_we(out_mem_we), .out_is_load(out_is_load), .out_flag_we(out_flag_we),
    .out_pc_load(out_pc_load), .out_cond(out_cond), .out_sign_ex(out_sign_ex),
    .out_rs_a(out_rs_a), .out_rs_b(out_rs_b),
    .out_fwd_a(out_fwd_a), .out_fwd_b(out_fwd_b), .out_stall(out_stall)
  );

  // Advance one clock and settle 2 units past the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_insn   = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    checks++; if (out_alu_op !== 4'h0) begin failures++; $display("FAIL rst_alu got=%h exp=0", out_alu_op); end
    checks++; if ({out_rd, out_rf_we, out_sign_ex, out_fwd_a, out_fwd_b} !== 9'd0) begin
      failures++; $display("FAIL rst_fields got=%b exp=0", {out_rd, out_rf_we, out_sign_ex, out_fwd_a, out_fwd_b}); end
    checks++; if (out_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", out_stall); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  // D100: ADD rd=1 A=1 B=2
  task automatic test_basic_add();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    checks++; if ({out_alu_op, out_rd, out_rf_we, out_flag_we, out_sign_ex} !== {4'b0000, 3'd1, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_ctrl got=%b exp=%b", {out_alu_op, out_rd, out_rf_we, out_flag_we, out_sign_ex}, {4'b0000, 3'd1, 3'b110}); end
    checks++; if ({out_rs_a, out_rs_b} !== {3'd1, 3'd2}) begin failures++; $display("FAIL add_rs got=%b exp=001010", {out_rs_a, out_rs_b}); end
    checks++; if ({out_fwd_a, out_fwd_b} !== 4'b0000) begin failures++; $display("FAIL add_fwd got=%b exp=0000", {out_fwd_a, out_fwd_b}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100;
    tick();
    in_insn = 16'hD900;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_rs_b} !== {1'b1, 3'd3}) begin failures++; $display("FAIL b2b_bundle got=%b exp=1011", {out_valid, out_rs_b}); end
    checks++; if (out_fwd_a !== 2'd1) begin failures++; $display("FAIL b2b_fwd_a got=%0d exp=1", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'd0) begin failures++; $display("FAIL b2b_fwd_b got=%0d exp=0", out_fwd_b); end
  endtask

  // Expected {alu_op, rf_we, mem_we, is_load, flag_we, pc_load, sign_ex, cond}
  task automatic test_decode_table();
    logic [15:0] insn [14];
    logic [12:0] exp  [14];
    logic [12:0] got;
    insn[0]  = 16'hD150; exp[0]  = {4'b0001, 6'b000100, 3'b001}; // CMP
    insn[1]  = 16'hD160; exp[1]  = {4'b1100, 6'b100100, 3'b001}; // MOV
    insn[2]  = 16'hD170; exp[2]  = {4'b1111, 6'b000000, 3'b001}; // func 0111
    insn[3]  = 16'hD1B0; exp[3]  = {4'b1011, 6'b100100, 3'b001}; // shift 1011
    insn[4]  = 16'hD1C0; exp[4]  = {4'b1100, 6'b100000, 3'b001}; // IDT
    insn[5]  = 16'hD1F0; exp[5]  = {4'b1111, 6'b000000, 3'b001}; // func 1111
    insn[6]  = 16'hD140; exp[6]  = {4'b0100, 6'b100100, 3'b001}; // XOR
    insn[7]  = 16'h5100; exp[7]  = {4'b0000, 6'b010001, 3'b001}; // ST
    insn[8]  = 16'h8200; exp[8]  = {4'b1100, 6'b100001, 3'b010}; // LI
    insn[9]  = 16'h8A00; exp[9]  = {4'b0000, 6'b100101, 3'b010}; // ADDI
    insn[10] = 16'hA000; exp[10] = {4'b0000, 6'b000011, 3'b000}; // B
    insn[11] = 16'hBD00; exp[11] = {4'b0000, 6'b000011, 3'b101}; // Bcc
    insn[12] = 16'h9000; exp[12] = {4'b1111, 6'b000001, 3'b000}; // imm other
    insn[13] = 16'h1A04; exp[13] = {4'b0000, 6'b101001, 3'b010}; // LD
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_insn = insn[i];
      tick();
      got = {out_alu_op, out_rf_we, out_mem_we, out_is_load, out_flag_we, out_pc_load, out_sign_ex, out_cond};
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dec_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL dec_ctrl[%0d] insn=%h got=%b exp=%b", i, insn[i], got, exp[i]); end
    end
    in_valid = 1'b0;
    checks++; if (out_rd !== 3'd3) begin failures++; $display("FAIL dec_ld_rd got=%0d exp=3", out_rd); end
  endtask

  task automatic test_forward();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100; tick();
    in_insn = 16'hD100; tick();
    in_insn = 16'hD900; tick();
    checks++; if (out_fwd_a !== 2'd1) begin failures++; $display("FAIL fwd_youngest got=%0d exp=1", out_fwd_a); end
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100; tick();
    in_insn = 16'h8200; tick();
    in_insn = 16'hD900; tick();
    checks++; if ({out_fwd_a, out_fwd_b} !== {2'd2, 2'd0}) begin failures++; $display("FAIL fwd_depth2 got=%b exp=1000", {out_fwd_a, out_fwd_b}); end
    in_insn = 16'hD200; tick();
    in_valid = 1'b0;
    checks++; if ({out_fwd_a, out_fwd_b} !== {2'd2, 2'd2}) begin failures++; $display("FAIL fwd_both got=%b exp=1010", {out_fwd_a, out_fwd_b}); end
  endtask

  task automatic test_load_use();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'h1A04; tick();
    in_insn = 16'hD900; #1;
    checks++; if ({out_valid, out_is_load, in_ready} !== 3'b110) begin failures++; $display("FAIL lu_detect got=%b exp=110", {out_valid, out_is_load, in_ready}); end
    tick();
    checks++; if ({out_valid, out_stall} !== 2'b01) begin failures++; $display("FAIL lu_bubble got=%b exp=01", {out_valid, out_stall}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_bubble_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_stall, out_rs_b} !== {2'b10, 3'd3}) begin failures++; $display("FAIL lu_issue got=%b exp=10011", {out_valid, out_stall, out_rs_b}); end
    checks++; if ({out_fwd_a, out_fwd_b} !== {2'd0, 2'd2}) begin failures++; $display("FAIL lu_fwd got=%b exp=0010", {out_fwd_a, out_fwd_b}); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100; tick();
    out_ready = 1'b0; in_insn = 16'hD900;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0b exp=0", c, in_ready); end
      tick();
      checks++; if ({out_valid, out_rd, out_rs_b} !== {1'b1, 3'd1, 3'd2}) begin failures++; $display("FAIL bp_hold[%0d] got=%b exp=1001010", c, {out_valid, out_rd, out_rs_b}); end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_rs_b, out_fwd_a} !== {1'b1, 3'd3, 2'd1}) begin failures++; $display("FAIL bp_release got=%b exp=101101", {out_valid, out_rs_b, out_fwd_a}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush_bubble();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'h1A04; tick();
    in_insn = 16'hD900; tick();
    checks++; if (out_stall !== 1'b1) begin failures++; $display("FAIL fl_bubble got=%0b exp=1", out_stall); end
    flush = 1'b1; tick();
    flush = 1'b0;
    checks++; if ({out_valid, out_stall, in_ready} !== 3'b001) begin failures++; $display("FAIL fl_clear got=%b exp=001", {out_valid, out_stall, in_ready}); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_fwd_a, out_fwd_b} !== 5'b10000) begin failures++; $display("FAIL fl_after got=%b exp=10000", {out_valid, out_fwd_a, out_fwd_b}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_valid = 1'b1; in_insn = 16'hD100; tick();
    in_insn = 16'hD900;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_rd, out_rf_we, out_alu_op, out_flag_we} !== 10'd0) begin
      failures++; $display("FAIL arst_out got=%b exp=0", {out_valid, out_rd, out_rf_we, out_alu_op, out_flag_we}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%0b exp=1", in_ready); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_decode_table();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush_bubble();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
